// File: rtl/led_display_driver_if.sv
// Display-side signal bundle for the LED display driver: counter value and
// limit flag in, active-low segment and anode drive out.
interface led_display_driver_if;
  logic [4:0] counter_in;
  logic       check;
  logic [6:0] seg;
  logic [1:0] an;

  modport master (output counter_in, output check, input seg, input an);
  modport slave  (input counter_in, input check, output seg, output an);
endinterface

// File: rtl/led_display_driver.sv
// Two-digit multiplexed common-anode 7-segment driver for a 0..31 counter,
// with leading-zero blanking and blinking while the counter sits at its limit.
module led_display_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                 clk,
  input  logic                 rst,
  led_display_driver_if.slave  disp
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [4:0]    value_r;
  logic          check_r;
  logic [RW-1:0] refresh_cnt;
  logic          digit_sel;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  logic [1:0]    tens;
  logic [3:0]    units;
  logic [6:0]    seg_next;
  logic [1:0]    an_next;
  logic          refresh_last;
  logic          blink_last;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'h40;
      4'd1:    enc = 7'h79;
      4'd2:    enc = 7'h24;
      4'd3:    enc = 7'h30;
      4'd4:    enc = 7'h19;
      4'd5:    enc = 7'h12;
      4'd6:    enc = 7'h02;
      4'd7:    enc = 7'h78;
      4'd8:    enc = 7'h00;
      4'd9:    enc = 7'h10;
      default: enc = 7'h7F;
    endcase
  endfunction

  // Value is at most 31, so a compare ladder replaces a real divider.
  always_comb begin
    tens  = 2'd0;
    units = value_r[3:0];
    if (value_r >= 5'd30) begin
      tens  = 2'd3;
      units = 4'(value_r - 5'd30);
    end else if (value_r >= 5'd20) begin
      tens  = 2'd2;
      units = 4'(value_r - 5'd20);
    end else if (value_r >= 5'd10) begin
      tens  = 2'd1;
      units = 4'(value_r - 5'd10);
    end
  end

  assign refresh_last = (refresh_cnt == RW'(REFRESH_DIV - 1));
  assign blink_last   = (blink_cnt == BW'(BLINK_DIV - 1));

  always_comb begin
    seg_next = 7'h7F;
    an_next  = 2'b11;
    if (!blink_phase) begin
      if (!digit_sel) begin
        an_next  = 2'b10;
        seg_next = enc(units);
      end else if (tens != 2'd0) begin
        an_next  = 2'b01;
        seg_next = enc({2'b00, tens});
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_r     <= '0;
      check_r     <= 1'b0;
      refresh_cnt <= '0;
      digit_sel   <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      disp.seg    <= 7'h7F;
      disp.an     <= 2'b11;
    end else begin
      value_r <= disp.counter_in;
      check_r <= disp.check;

      if (refresh_last) begin
        refresh_cnt <= '0;
        digit_sel   <= ~digit_sel;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end

      // Dropping the limit flag snaps the display back on immediately.
      if (!check_r) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (blink_last) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      disp.seg <= seg_next;
      disp.an  <= an_next;
    end
  end

endmodule

// File: tb/tb_led_display_driver.sv
// Directed bench for led_display_driver with REFRESH_DIV=4, BLINK_DIV=8;
// cyc numbers the rising edges since the last reset release.
module tb_led_display_driver;
  logic clk;
  logic rst;
  int   cyc;
  int   n_assert;
  int   n_fail;

  led_display_driver_if bus ();

  led_display_driver #(
    .REFRESH_DIV (4),
    .BLINK_DIV   (8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .disp (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [6:0] es, input logic [1:0] ea);
    n_assert++;
    assert ({bus.seg, bus.an} === {es, ea})
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: seg=%h an=%b, required seg=%h an=%b",
             tag, cyc, bus.seg, bus.an, es, ea);
    end
  endtask

  // One edge, then sample on the falling edge; both anodes low is never legal.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    n_assert++;
    assert (bus.an !== 2'b00)
    else begin
      n_fail++;
      $error("FAIL both_anodes cyc=%0d: an=%b, required not 00", cyc, bus.an);
    end
  endtask

  task automatic run(input int n, input string tag, input logic [6:0] es, input logic [1:0] ea);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, es, ea);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    rst      = 1'b1;
    bus.counter_in = 5'd0;
    bus.check      = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("in_reset", 7'h7F, 2'b11);
    end
    #2 rst = 1'b0;
    cyc = 0;

    run(2, "post_rst_zero", 7'h40, 2'b10);
    bus.counter_in = 5'd27;
    run(1, "old_value_0", 7'h40, 2'b10);
    run(1, "v27_units", 7'h78, 2'b10);
    run(4, "v27_tens", 7'h24, 2'b01);
    run(4, "v27_units", 7'h78, 2'b10);
    run(4, "v27_tens", 7'h24, 2'b01);

    bus.counter_in = 5'd5;
    run(1, "old_value_27", 7'h78, 2'b10);
    run(3, "v5_units", 7'h12, 2'b10);
    run(4, "v5_tens_blank", 7'h7F, 2'b11);

    bus.counter_in = 5'd31;
    bus.check      = 1'b1;
    run(1, "old_value_5", 7'h12, 2'b10);
    run(3, "v31_on_units", 7'h79, 2'b10);
    run(4, "v31_on_tens", 7'h30, 2'b01);
    run(1, "v31_on_units", 7'h79, 2'b10);
    run(8, "blink_off", 7'h7F, 2'b11);
    run(3, "blink_on2_units", 7'h79, 2'b10);
    run(4, "blink_on2_tens", 7'h30, 2'b01);
    run(1, "blink_on2_units", 7'h79, 2'b10);
    run(2, "blink_off2", 7'h7F, 2'b11);

    bus.check = 1'b0;
    run(2, "drop_latency", 7'h7F, 2'b11);
    run(3, "drop_tens", 7'h30, 2'b01);
    run(1, "drop_units", 7'h79, 2'b10);

    bus.check = 1'b1;
    run(3, "rearm_units", 7'h79, 2'b10);
    run(4, "rearm_tens", 7'h30, 2'b01);
    run(2, "rearm_units", 7'h79, 2'b10);
    run(8, "rearm_off", 7'h7F, 2'b11);
    run(1, "rearm_on", 7'h79, 2'b10);

    bus.counter_in = 5'd20;
    bus.check      = 1'b0;
    #2 rst = 1'b1;
    #1 check("async_rst", 7'h7F, 2'b11);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_hold", 7'h7F, 2'b11);
    end
    #2 rst = 1'b0;
    cyc = 0;
    run(4, "v20_units", 7'h40, 2'b10);
    run(4, "v20_tens", 7'h24, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
